// File: rtl/unidade_controle.sv
// Game control unit: Moore FSM sequencing rounds, plays and
// end-of-game outcomes for the memory-sequence datapath.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimRodada,
    input  logic       fimTotal,
    input  logic       fimT,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraCL,
    output logic       contaCL,
    output logic       zeraR,
    output logic       registraR,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    logic [3:0] estado_q;
    logic [3:0] estado_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Unused codes fall through the default and recover to INICIAL.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)
                    estado_d = REGISTRA;
                else if (fimT)
                    estado_d = FIM_TIMEOUT;
                else
                    estado_d = ESPERA_JOGADA;
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    estado_d = FIM_ERROU;
                else if (!fimRodada)
                    estado_d = PROXIMA_JOGADA;
                else if (!fimTotal)
                    estado_d = PROXIMA_RODADA;
                else
                    estado_d = FIM_ACERTOU;
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTOU:    estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:      estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraCL    = 1'b0;
        contaCL   = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        conta     = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraC  = 1'b1;
                zeraCL = 1'b1;
                zeraR  = 1'b1;
            end
            INICIO_RODADA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA_JOGADA:  conta     = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: contaC    = 1'b1;
            PROXIMA_RODADA: contaCL   = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed game scenarios
// with a queue of expected state/output snapshots per cycle.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT;
    logic       zeraC, contaC, zeraCL, contaCL, zeraR, registraR;
    logic       conta, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    // {state[3:0], outputs[10:0]}
    logic [14:0] sb[$];
    logic [10:0] obs;

    always #5 clock = ~clock;

    unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual),
        .fimRodada(fimRodada), .fimTotal(fimTotal), .fimT(fimT),
        .zeraC(zeraC), .contaC(contaC), .zeraCL(zeraCL),
        .contaCL(contaCL), .zeraR(zeraR), .registraR(registraR),
        .conta(conta), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    assign obs = {zeraC, contaC, zeraCL, contaCL, zeraR, registraR,
                  conta, pronto, acertou, errou, timeout};

    // Expected output vector for a state code, from the output table.
    function automatic logic [10:0] exp_out(input logic [3:0] st);
        case (st)
            4'h1:    return 11'b10101000000;
            4'h2:    return 11'b10001000000;
            4'h3:    return 11'b00000010000;
            4'h4:    return 11'b00000100000;
            4'h6:    return 11'b01000000000;
            4'h7:    return 11'b00010000000;
            4'hA:    return 11'b00000001100;
            4'hD:    return 11'b00000001001;
            4'hE:    return 11'b00000001010;
            default: return 11'b00000000000;
        endcase
    endfunction

    // s = {iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT, next_state}
    task automatic apply(input logic [9:0] s);
        {iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT} = s[9:4];
        sb.push_back({s[3:0], exp_out(s[3:0])});
    endtask

    task automatic test_reset();
        logic [9:0]  seq[$];
        logic [14:0] e;
        int n_zcl = 0;
        reset = 1'b1;
        apply({6'b000000, 4'h0});
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({db_estado, obs} !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%b want %h/%b",
                     db_estado, obs, e[14:11], e[10:0]);
        end
        @(negedge clock);
        reset = 1'b0;
        seq = '{{6'b100000, 4'h1}, {6'b000000, 4'h2},
                {6'b000000, 4'h3}, {6'b000000, 4'h3}};
        foreach (seq[i]) begin
            @(negedge clock);
            apply(seq[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            if (zeraCL) n_zcl++;
            n_checks++;
            if ({db_estado, obs} !== e) begin
                n_fail++;
                $display("FAIL start[%0d]: got %h/%b want %h/%b", i,
                         db_estado, obs, e[14:11], e[10:0]);
            end
        end
        n_checks++;
        if (n_zcl !== 1) begin
            n_fail++;
            $display("FAIL zeraCL_pulses: got %0d want 1", n_zcl);
        end
    endtask

    task automatic test_proxima_rodada();
        logic [9:0]  seq[$];
        logic [14:0] e;
        int n_cc = 0, n_ccl = 0;
        // iniciar high mid-game must be ignored
        seq = '{{6'b011100, 4'h4}, {6'b101100, 4'h5},
                {6'b001100, 4'h7}, {6'b001100, 4'h2},
                {6'b001100, 4'h3}};
        foreach (seq[i]) begin
            @(negedge clock);
            apply(seq[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            if (contaC) n_cc++;
            if (contaCL) n_ccl++;
            n_checks++;
            if ({db_estado, obs} !== e) begin
                n_fail++;
                $display("FAIL rodada[%0d]: got %h/%b want %h/%b", i,
                         db_estado, obs, e[14:11], e[10:0]);
            end
        end
        n_checks++;
        if (n_cc !== 0 || n_ccl !== 1) begin
            n_fail++;
            $display("FAIL rodada_pulses: got contaC=%0d contaCL=%0d want 0/1",
                     n_cc, n_ccl);
        end
    endtask

    task automatic test_acertou();
        logic [9:0]  seq[$];
        logic [14:0] e;
        int n_six = 0;
        seq = '{{6'b011000, 4'h4}, {6'b001000, 4'h5},
                {6'b001000, 4'h6}, {6'b001000, 4'h3},
                {6'b011110, 4'h4}, {6'b001110, 4'h5},
                {6'b001110, 4'hA}};
        for (int k = 0; k < 10; k++) seq.push_back({6'b000000, 4'hA});
        foreach (seq[i]) begin
            @(negedge clock);
            apply(seq[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            if (db_estado == 4'h6) n_six++;
            n_checks++;
            if ({db_estado, obs} !== e) begin
                n_fail++;
                $display("FAIL acertou[%0d]: got %h/%b want %h/%b", i,
                         db_estado, obs, e[14:11], e[10:0]);
            end
        end
        n_checks++;
        if (n_six !== 1) begin
            n_fail++;
            $display("FAIL visits_6: got %0d want 1", n_six);
        end
    endtask

    task automatic test_errou();
        logic [9:0]  seq[$];
        logic [14:0] e;
        seq = '{{6'b100000, 4'h1}, {6'b000000, 4'h2},
                {6'b000000, 4'h3}, {6'b010000, 4'h4},
                {6'b000000, 4'h5}, {6'b000000, 4'hE},
                {6'b000000, 4'hE}, {6'b100000, 4'h1},
                {6'b000000, 4'h2}, {6'b000000, 4'h3}};
        foreach (seq[i]) begin
            @(negedge clock);
            apply(seq[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({db_estado, obs} !== e) begin
                n_fail++;
                $display("FAIL errou[%0d]: got %h/%b want %h/%b", i,
                         db_estado, obs, e[14:11], e[10:0]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0]  seq[$];
        logic [14:0] e;
        // second play: fimT and jogada_feita together, play wins
        seq = '{{6'b000001, 4'hD}, {6'b000000, 4'hD},
                {6'b100000, 4'h1}, {6'b000000, 4'h2},
                {6'b000000, 4'h3}, {6'b010001, 4'h4},
                {6'b000000, 4'h5}};
        foreach (seq[i]) begin
            @(negedge clock);
            apply(seq[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({db_estado, obs} !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %h/%b want %h/%b", i,
                         db_estado, obs, e[14:11], e[10:0]);
            end
        end
    endtask

    task automatic test_reset_mid_and_illegal();
        logic [14:0] e;
        // currently in state 5; assert reset between edges
        #2;
        apply({6'b001100, 4'h0});
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({db_estado, obs} !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b want %h/%b",
                     db_estado, obs, e[14:11], e[10:0]);
        end
        @(negedge clock);
        apply({6'b110000, 4'h0});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({db_estado, obs} !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %h/%b want %h/%b",
                     db_estado, obs, e[14:11], e[10:0]);
        end
        @(negedge clock);
        reset = 1'b0;
        apply({6'b000000, 4'hF});
        force dut.estado_q = 4'hF;
        #1;
        release dut.estado_q;
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({db_estado, obs} !== e) begin
            n_fail++;
            $display("FAIL illegal_F: got %h/%b want %h/%b",
                     db_estado, obs, e[14:11], e[10:0]);
        end
        apply({6'b000000, 4'h0});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({db_estado, obs} !== e) begin
            n_fail++;
            $display("FAIL illegal_recover: got %h/%b want %h/%b",
                     db_estado, obs, e[14:11], e[10:0]);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (int'(acertou) + int'(errou) + int'(timeout)) > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL flags_exclusive: got %b%b%b want one-hot or zero",
                     acertou, errou, timeout);
        end
    end

    initial begin
        {iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT} = '0;
        reset = 1'b0;
        #2;
        test_reset();
        test_proxima_rodada();
        test_acertou();
        test_errou();
        test_timeout();
        test_reset_mid_and_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have these ports:
  clock  in  1  single system clock, all state changes on rising edge
  reset  in  1  asynchronous, active-high; forces state inicial
  iniciar  in  1  start or restart request, level-sampled
  jogada_feita  in  1  one-cycle pulse from the datapath edge detector
  igual  in  1  stored play equals ROM data at the current address
  fimRodada  in  1  play address equals current round index
  fimTotal  in  1  round index equals the last round (limit chosen by modo in the datapath)
  fimT  in  1  play timeout reached (contador_m fim)
  zeraC, contaC  out  1  clear / increment the play-address counter
  zeraCL, contaCL  out  1  clear / increment the round counter
  zeraR, registraR  out  1  clear / load the play register
  conta  out  1  timeout counter enable
  pronto  out  1  game finished (any outcome)
  acertou  out  1  game won
  errou  out  1  game lost by wrong play
  timeout  out  1  game lost by timeout
  db_estado  out  4  current state code
REQ-002 Reset SHALL be asynchronous and active-high on port reset, with a single clock domain on port clock.

Function
REQ-003 The block SHALL be a Moore FSM, with every output a decode of the registered state only.
REQ-004 State codes SHALL be: inicial 0x0, preparacao 0x1, inicio_rodada 0x2, espera_jogada 0x3, registra 0x4, comparacao 0x5, proxima_jogada 0x6, proxima_rodada 0x7, fim_acertou 0xA, fim_timeout 0xD, fim_errou 0xE.
REQ-005 From inicial, the FSM SHALL go to preparacao when iniciar=1 and SHALL otherwise stay in inicial.
REQ-006 preparacao SHALL assert zeraC, zeraCL and zeraR, and SHALL go unconditionally to inicio_rodada.
REQ-007 inicio_rodada SHALL assert zeraC and zeraR, and SHALL go unconditionally to espera_jogada.
REQ-008 espera_jogada SHALL assert conta and SHALL transition as follows:
  - jogada_feita=1: go to registra.
  - jogada_feita=0 and fimT=1: go to fim_timeout.
  - otherwise: stay in espera_jogada.
REQ-009 When jogada_feita=1 and fimT=1 arrive in the same cycle, jogada_feita SHALL win.
REQ-010 registra SHALL assert registraR and SHALL go unconditionally to comparacao.
REQ-011 comparacao SHALL transition as follows:
  - igual=0: go to fim_errou.
  - igual=1 and fimRodada=0: go to proxima_jogada.
  - igual=1, fimRodada=1, fimTotal=0: go to proxima_rodada.
  - igual=1, fimRodada=1, fimTotal=1: go to fim_acertou.
REQ-012 proxima_jogada SHALL assert contaC and SHALL go to espera_jogada.
REQ-013 proxima_rodada SHALL assert contaCL and SHALL go to inicio_rodada.
REQ-014 Each final state SHALL assert pronto together with its flag: acertou in fim_acertou, errou in fim_errou, timeout in fim_timeout.
REQ-015 Each final state SHALL hold until iniciar=1, then go to preparacao; reset SHALL NOT be required to replay.
REQ-016 Every control output SHALL be high for exactly one cycle per visit to its asserting state; conta is the exception and stays high for the whole espera_jogada dwell.
REQ-017 No two of acertou, errou and timeout SHALL ever be high together.
REQ-018 Unused state codes SHALL go to inicial on the next clock.
REQ-019 iniciar SHALL be ignored in every state except inicial and the final states.

Reset
REQ-020 While reset=1, the state SHALL be inicial immediately, independent of clock.
REQ-021 While reset=1, db_estado SHALL be 0x0 and all other outputs SHALL be 0.
REQ-022 Reset asserted mid-game (any state) SHALL abort to inicial with no further counter or register strobes.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Reset, then iniciar=1 for 1 cycle -> db_estado follows 0,1,2,3; zeraCL pulses once; conta=1 in state 3.
  - Round 0 with fimRodada=1, igual=1, fimTotal=0 after jogada_feita -> states 4,5,7,2,3; contaCL pulses once; contaC is never high.
  - Round with fimRodada=0 then 1, igual=1, fimTotal=1 -> visits 6 once, ends in 0xA; pronto=acertou=1 held for 10 cycles.
  - igual=0 at comparacao -> ends in 0xE with errou=1 and pronto=1; then iniciar=1 -> state 0x1.
  - fimT=1 in state 3 -> 0xD with timeout=1; a separate run with fimT and jogada_feita high together -> goes to 0x4.
  - Reset pulsed while in state 0x5 -> 0x0 asynchronously with all outputs 0; force state 0xF -> 0x0 after one clock.
